// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults and the per-axis segment state used by both
// the horizontal and vertical counters.
package vga_timing_pkg;

   localparam int COUNT_W      = 10;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;

   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   typedef enum logic [1:0] {
      ST_ACTIVE,
      ST_FP,
      ST_SYNC,
      ST_BP
   } axis_state_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter plus ACTIVE/FP/SYNC/BP segment FSM.
// Sync is registered here; next-cycle active and the wrap flag feed the top.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int SEG_ACTIVE = DEF_H_ACTIVE,
   parameter int SEG_FP     = DEF_H_FP,
   parameter int SEG_SYNC   = DEF_H_SYNC,
   parameter int SEG_BP     = DEF_H_BP
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_advance,
   output logic [COUNT_W-1:0] o_count,
   output logic               o_sync_n,
   output logic               o_active_next,
   output logic               o_wrap
);

   localparam int TOTAL = SEG_ACTIVE + SEG_FP + SEG_SYNC + SEG_BP;
   localparam logic [COUNT_W-1:0] LAST       = COUNT_W'(TOTAL - 1);
   localparam logic [COUNT_W-1:0] FP_START   = COUNT_W'(SEG_ACTIVE);
   localparam logic [COUNT_W-1:0] SYNC_START = COUNT_W'(SEG_ACTIVE + SEG_FP);
   localparam logic [COUNT_W-1:0] BP_START   = COUNT_W'(SEG_ACTIVE + SEG_FP + SEG_SYNC);

   logic [COUNT_W-1:0] count_q, count_d;
   axis_state_t        state_q, state_d;
   logic               sync_n_q, sync_n_d;
   logic               wrap;

   always_comb begin
      count_d  = count_q;
      state_d  = state_q;
      wrap     = i_advance && (count_q == LAST);
      if (i_advance) begin
         count_d = wrap ? '0 : count_q + 1'b1;
         // The segment changes on the edge where the count lands on its first position.
         unique case (state_q)
            ST_ACTIVE: if (count_d == FP_START)   state_d = ST_FP;
            ST_FP:     if (count_d == SYNC_START) state_d = ST_SYNC;
            ST_SYNC:   if (count_d == BP_START)   state_d = ST_BP;
            ST_BP:     if (count_d == '0)         state_d = ST_ACTIVE;
            default:                              state_d = ST_BP;
         endcase
      end
      sync_n_d = (state_d != ST_SYNC);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         count_q  <= LAST;
         state_q  <= ST_BP;
         sync_n_q <= 1'b1;
      end else begin
         count_q  <= count_d;
         state_q  <= state_d;
         sync_n_q <= sync_n_d;
      end
   end

   assign o_count       = count_q;
   assign o_sync_n      = sync_n_q;
   assign o_active_next = (state_d == ST_ACTIVE);
   assign o_wrap        = wrap;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: horizontal and vertical axis counters chained on the
// line wrap, with all outputs registered on the same edge.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic               i_clk,
   input  logic               i_rst,
   output logic [COUNT_W-1:0] o_hcount,
   output logic [COUNT_W-1:0] o_vcount,
   output logic               o_hsync,
   output logic               o_vsync,
   output logic               o_active,
   output logic               o_line_start,
   output logic               o_frame_start,
   output logic [7:0]         o_frame_cnt
);

   logic h_active_d, v_active_d, h_wrap, v_wrap;
   logic active_q, active_d;
   logic line_start_q, line_start_d;
   logic frame_start_q, frame_start_d;
   logic [7:0] frame_cnt_q, frame_cnt_d;

   vga_axis_counter #(
      .SEG_ACTIVE(H_ACTIVE), .SEG_FP(H_FP), .SEG_SYNC(H_SYNC), .SEG_BP(H_BP)
   ) u_h_axis (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_advance     (1'b1),
      .o_count       (o_hcount),
      .o_sync_n      (o_hsync),
      .o_active_next (h_active_d),
      .o_wrap        (h_wrap)
   );

   vga_axis_counter #(
      .SEG_ACTIVE(V_ACTIVE), .SEG_FP(V_FP), .SEG_SYNC(V_SYNC), .SEG_BP(V_BP)
   ) u_v_axis (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_advance     (h_wrap),
      .o_count       (o_vcount),
      .o_sync_n      (o_vsync),
      .o_active_next (v_active_d),
      .o_wrap        (v_wrap)
   );

   // A wrap on this edge means the next position is column 0 (and row 0 if both wrap).
   always_comb begin
      active_d      = h_active_d & v_active_d;
      line_start_d  = h_wrap;
      frame_start_d = h_wrap & v_wrap;
      frame_cnt_d   = frame_cnt_q + (frame_start_d ? 8'd1 : 8'd0);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         active_q      <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_cnt_q   <= 8'd0;
      end else begin
         active_q      <= active_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   assign o_active      = active_q;
   assign o_line_start  = line_start_q;
   assign o_frame_start = frame_start_q;
   assign o_frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default, medium and tiny timings checked against a
// position model derived from the number of clock edges since reset release.
module tb_vga_sync_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_d = 1'b1, rst_m = 1'b1, rst_s = 1'b1;

   logic [9:0] d_h, d_v, m_h, m_v, s_h, s_v;
   logic d_hs, d_vs, d_act, d_ls, d_fs;
   logic m_hs, m_vs, m_act, m_ls, m_fs;
   logic s_hs, s_vs, s_act, s_ls, s_fs;
   logic [7:0] d_fc, m_fc, s_fc;

   int vectors = 0;
   int miscompares = 0;

   longint n_d, n_m, n_s;

   typedef struct packed {
      logic [9:0] h;
      logic [9:0] v;
      logic       hs;
      logic       vs;
      logic       act;
      logic       ls;
      logic       fs;
      logic [7:0] fc;
   } obs_t;

   obs_t obs_d, obs_m, obs_s;
   assign obs_d = {d_h, d_v, d_hs, d_vs, d_act, d_ls, d_fs, d_fc};
   assign obs_m = {m_h, m_v, m_hs, m_vs, m_act, m_ls, m_fs, m_fc};
   assign obs_s = {s_h, s_v, s_hs, s_vs, s_act, s_ls, s_fs, s_fc};

   vga_sync_gen u_dut_def (
      .i_clk(clk), .i_rst(rst_d),
      .o_hcount(d_h), .o_vcount(d_v), .o_hsync(d_hs), .o_vsync(d_vs),
      .o_active(d_act), .o_line_start(d_ls), .o_frame_start(d_fs), .o_frame_cnt(d_fc)
   );

   vga_sync_gen #(
      .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
      .V_ACTIVE(30), .V_FP(3), .V_SYNC(2), .V_BP(5)
   ) u_dut_med (
      .i_clk(clk), .i_rst(rst_m),
      .o_hcount(m_h), .o_vcount(m_v), .o_hsync(m_hs), .o_vsync(m_vs),
      .o_active(m_act), .o_line_start(m_ls), .o_frame_start(m_fs), .o_frame_cnt(m_fc)
   );

   vga_sync_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
   ) u_dut_small (
      .i_clk(clk), .i_rst(rst_s),
      .o_hcount(s_h), .o_vcount(s_v), .o_hsync(s_hs), .o_vsync(s_vs),
      .o_active(s_act), .o_line_start(s_ls), .o_frame_start(s_fs), .o_frame_cnt(s_fc)
   );

   // Edges seen since each reset released; the model derives everything from this.
   always @(posedge clk or posedge rst_d) if (rst_d) n_d <= 0; else n_d <= n_d + 1;
   always @(posedge clk or posedge rst_m) if (rst_m) n_m <= 0; else n_m <= n_m + 1;
   always @(posedge clk or posedge rst_s) if (rst_s) n_s <= 0; else n_s <= n_s + 1;

   function automatic obs_t model(int ha, int hfp, int hsw, int hbp,
                                  int va, int vfp, int vsw, int vbp, longint n);
      obs_t e;
      int ht, vt, h, v;
      longint ft, p;
      ht = ha + hfp + hsw + hbp;
      vt = va + vfp + vsw + vbp;
      ft = longint'(ht) * vt;
      if (n == 0) begin
         e = {10'(ht - 1), 10'(vt - 1), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
      end else begin
         p    = (n - 1) % ft;
         h    = int'(p % ht);
         v    = int'(p / ht);
         e.h  = 10'(h);
         e.v  = 10'(v);
         e.hs = !(h >= ha + hfp && h < ha + hfp + hsw);
         e.vs = !(v >= va + vfp && v < va + vfp + vsw);
         e.act = (h < ha) && (v < va);
         e.ls = (h == 0);
         e.fs = (h == 0) && (v == 0);
         e.fc = 8'(((n - 1) / ft + 1) % 256);
      end
      return e;
   endfunction

   function automatic obs_t exp_d(longint n); return model(640, 16, 96, 48, 480, 10, 2, 33, n); endfunction
   function automatic obs_t exp_m(longint n); return model(40, 4, 8, 4, 30, 3, 2, 5, n);        endfunction
   function automatic obs_t exp_s(longint n); return model(8, 2, 3, 1, 4, 1, 1, 1, n);          endfunction

   task automatic test_reset();
      obs_t rd, rm, rs, first;
      rd = {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
      rm = {10'd55,  10'd39,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
      rs = {10'd13,  10'd6,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
      first = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1};
      @(negedge clk);
      vectors++;
      if (obs_d !== rd) begin miscompares++; $display("[TB] FAIL reset_hold_def: got %h, expected %h", obs_d, rd); end
      vectors++;
      if (obs_m !== rm) begin miscompares++; $display("[TB] FAIL reset_hold_med: got %h, expected %h", obs_m, rm); end
      vectors++;
      if (obs_s !== rs) begin miscompares++; $display("[TB] FAIL reset_hold_small: got %h, expected %h", obs_s, rs); end
      rst_d = 1'b0;
      rst_m = 1'b0;
      rst_s = 1'b0;
      @(negedge clk);
      vectors++;
      if (obs_d !== first) begin miscompares++; $display("[TB] FAIL release_def: got %h, expected %h", obs_d, first); end
      vectors++;
      if (obs_m !== first) begin miscompares++; $display("[TB] FAIL release_med: got %h, expected %h", obs_m, first); end
      vectors++;
      if (obs_s !== first) begin miscompares++; $display("[TB] FAIL release_small: got %h, expected %h", obs_s, first); end
   endtask

   task automatic test_line_default();
      int hs_low = 0, act_cnt = 0, first_h = -1, last_h = -1;
      obs_t e;
      for (int i = 0; i < 800; i++) begin
         e = exp_d(n_d);
         vectors++;
         if (obs_d !== e) begin miscompares++; $display("[TB] FAIL line_def_cycle: got %h, expected %h", obs_d, e); end
         if (d_hs === 1'b0) begin
            if (first_h < 0) first_h = int'(d_h);
            hs_low++;
         end
         if (d_act === 1'b1) act_cnt++;
         last_h = int'(d_h);
         @(negedge clk);
      end
      vectors++;
      if (hs_low != 96) begin miscompares++; $display("[TB] FAIL hsync_width: got %0d, expected 96", hs_low); end
      vectors++;
      if (first_h != 656) begin miscompares++; $display("[TB] FAIL hsync_start: got %0d, expected 656", first_h); end
      vectors++;
      if (act_cnt != 640) begin miscompares++; $display("[TB] FAIL active_width: got %0d, expected 640", act_cnt); end
      vectors++;
      if (last_h != 799 || d_h !== 10'd0 || d_v !== 10'd1) begin
         miscompares++;
         $display("[TB] FAIL line_wrap: got last=%0d now=(%0d,%0d), expected last=799 now=(0,1)", last_h, d_h, d_v);
      end
   endtask

   task automatic test_mid_reset_default();
      bit found = 0;
      int hs_low = 0, first_h = -1;
      obs_t e, rd, first;
      rd = {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
      first = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1};
      for (int i = 0; i < 3000; i++) begin
         if (d_h == 10'd300 && d_v == 10'd2) begin found = 1; break; end
         e = exp_d(n_d);
         vectors++;
         if (obs_d !== e) begin miscompares++; $display("[TB] FAIL pre_reset_def: got %h, expected %h", obs_d, e); end
         @(negedge clk);
      end
      vectors++;
      if (!found) begin miscompares++; $display("[TB] FAIL reach_300_2: got timeout, expected position (300,2)"); end
      rst_d = 1'b1;
      #1;
      vectors++;
      if (obs_d !== rd) begin miscompares++; $display("[TB] FAIL async_reset: got %h, expected %h", obs_d, rd); end
      @(negedge clk);
      vectors++;
      if (obs_d !== rd) begin miscompares++; $display("[TB] FAIL reset_held: got %h, expected %h", obs_d, rd); end
      rst_d = 1'b0;
      @(negedge clk);
      vectors++;
      if (obs_d !== first) begin miscompares++; $display("[TB] FAIL restart_def: got %h, expected %h", obs_d, first); end
      for (int i = 0; i < 800; i++) begin
         e = exp_d(n_d);
         vectors++;
         if (obs_d !== e) begin miscompares++; $display("[TB] FAIL post_reset_def: got %h, expected %h", obs_d, e); end
         if (d_hs === 1'b0) begin
            if (first_h < 0) first_h = int'(d_h);
            hs_low++;
         end
         @(negedge clk);
      end
      vectors++;
      if (hs_low != 96 || first_h != 656) begin
         miscompares++;
         $display("[TB] FAIL post_reset_hsync: got %0d from %0d, expected 96 from 656", hs_low, first_h);
      end
   endtask

   task automatic test_medium_frame();
      bit found = 0;
      int vs_low = 0, fs_cnt = 0, vs_h = -1, vs_v = -1;
      logic [7:0] fc0;
      obs_t e;
      for (int i = 0; i < 2300; i++) begin
         if (m_fs === 1'b1) begin found = 1; break; end
         @(negedge clk);
      end
      vectors++;
      if (!found) begin miscompares++; $display("[TB] FAIL med_wait_fs: got timeout, expected frame start"); end
      fc0 = m_fc;
      for (int i = 0; i < 2240; i++) begin
         e = exp_m(n_m);
         vectors++;
         if (obs_m !== e) begin miscompares++; $display("[TB] FAIL med_cycle: got %h, expected %h", obs_m, e); end
         if (m_vs === 1'b0) begin
            if (vs_h < 0) begin vs_h = int'(m_h); vs_v = int'(m_v); end
            vs_low++;
         end
         if (m_fs === 1'b1) fs_cnt++;
         @(negedge clk);
      end
      vectors++;
      if (fs_cnt != 1 || m_fs !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL med_frame_period: got %0d pulses, fs_now=%b, expected 1 and 1", fs_cnt, m_fs);
      end
      vectors++;
      if (vs_low != 112 || vs_h != 0 || vs_v != 33) begin
         miscompares++;
         $display("[TB] FAIL med_vsync: got %0d at (%0d,%0d), expected 112 at (0,33)", vs_low, vs_h, vs_v);
      end
      vectors++;
      if (m_fc !== fc0 + 8'd1) begin miscompares++; $display("[TB] FAIL med_frame_cnt: got %0d, expected %0d", m_fc, fc0 + 8'd1); end
   endtask

   task automatic test_small_frames();
      bit found = 0;
      int fs_cnt = 0, ls_cnt = 0, hs_low = 0, vs_low = 0;
      logic [7:0] fc0;
      obs_t e;
      for (int i = 0; i < 200; i++) begin
         if (s_fs === 1'b1) begin found = 1; break; end
         @(negedge clk);
      end
      vectors++;
      if (!found) begin miscompares++; $display("[TB] FAIL small_wait_fs: got timeout, expected frame start"); end
      fc0 = s_fc;
      for (int i = 0; i < 256 * 98; i++) begin
         e = exp_s(n_s);
         vectors++;
         if (obs_s !== e) begin miscompares++; $display("[TB] FAIL small_cycle: got %h, expected %h", obs_s, e); end
         if (s_fs === 1'b1) fs_cnt++;
         if (s_ls === 1'b1) ls_cnt++;
         if (s_hs === 1'b0) hs_low++;
         if (s_vs === 1'b0) vs_low++;
         @(negedge clk);
      end
      vectors++;
      if (fs_cnt != 256 || ls_cnt != 1792) begin
         miscompares++;
         $display("[TB] FAIL small_pulses: got fs=%0d ls=%0d, expected fs=256 ls=1792", fs_cnt, ls_cnt);
      end
      vectors++;
      if (hs_low != 5376 || vs_low != 3584) begin
         miscompares++;
         $display("[TB] FAIL small_sync_len: got hs=%0d vs=%0d, expected hs=5376 vs=3584", hs_low, vs_low);
      end
      vectors++;
      if (s_fs !== 1'b1 || s_fc !== fc0) begin
         miscompares++;
         $display("[TB] FAIL small_fc_wrap: got fs=%b fc=%0d, expected fs=1 fc=%0d", s_fs, s_fc, fc0);
      end
   endtask

   task automatic test_random_reset_small();
      obs_t e;
      int run, hold;
      for (int k = 0; k < 8; k++) begin
         run  = int'($urandom_range(1, 250));
         hold = int'($urandom_range(1, 3));
         for (int i = 0; i < run; i++) begin
            e = exp_s(n_s);
            vectors++;
            if (obs_s !== e) begin miscompares++; $display("[TB] FAIL rand_run: got %h, expected %h", obs_s, e); end
            @(negedge clk);
         end
         rst_s = 1'b1;
         #1;
         e = exp_s(0);
         vectors++;
         if (obs_s !== e) begin miscompares++; $display("[TB] FAIL rand_async_reset: got %h, expected %h", obs_s, e); end
         for (int i = 0; i < hold; i++) @(negedge clk);
         rst_s = 1'b0;
         @(negedge clk);
         e = exp_s(n_s);
         vectors++;
         if (obs_s !== e) begin miscompares++; $display("[TB] FAIL rand_restart: got %h, expected %h", obs_s, e); end
      end
   endtask

   initial begin
      test_reset();
      test_line_default();
      test_mid_reset_default();
      test_medium_frame();
      test_small_frames();
      test_random_reset_small();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
